retire_queue: RTL and testbench
===============================

# retire_queue

In-order retirement queue for the Tomasulo out-of-order core; it is the return end of the tag protocol. The queue records every tag-holding instruction in dispatch order, captures its result when the tag appears on the CDB, and retires completed instructions strictly in program order. On retirement it publishes the register write and hands the tag back to the tag FIFO over RB_Tag/RB_Tag_Valid. It sits between the dispatch unit, the CDB, the register file write port and the tag FIFO.

## Interface
- DSIZE, 5, tag width
- ASIZE, 5, log2 of queue depth (32 entries, one per tag)
- RSIZE, 5, architectural register index width
- WSIZE, 32, result data width
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- Dispatch_en  in  1  push one entry (dispatch of instruction with destination)
- Dispatch_Tag  in  DSIZE  tag allocated from tag FIFO
- Dispatch_Rd  in  RSIZE  destination register
- CDB_Valid  in  1  result broadcast valid
- CDB_Tag  in  DSIZE  tag of broadcast result
- CDB_Data  in  WSIZE  broadcast result
- RF_Ready  in  1  register file write port free this cycle
- RB_Tag_Valid  out  1  retire strobe, one cycle per retired entry; also register-file write enable
- RB_Tag  out  DSIZE  retired tag, returned to tag FIFO
- RB_Rd  out  RSIZE  retired destination register
- RB_Data  out  WSIZE  retired result
- rq_full  out  1  all 2^ASIZE entries occupied
- rq_empty  out  1  no entries occupied

## Operation
- Circular buffer of 2^ASIZE entries; each entry holds tag, rd, data, valid, done. Pointers wptr/rptr are ASIZE+1 bits wide, and the MSB is the wrap bit.
- rq_empty = (wptr == rptr). rq_full = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]). Both are combinational from the pointers.
- Push: when Dispatch_en && !rq_full, write {tag, rd, valid=1, done=0} at wptr at the edge, then wptr+1. Dispatch_en while full is ignored and the entry is dropped.
- Complete: when CDB_Valid, compare CDB_Tag associatively against every entry with valid=1 && done=0 as of before the edge. The matching entry gets done<=1 and data<=CDB_Data. No match means no effect.
- A CDB tag matching an entry already done is ignored, and data is not overwritten.
- A CDB tag equal to the Dispatch_Tag pushed on the same edge does not match the new entry.
- Retire condition, evaluated before the edge: !rq_empty && head.done && RF_Ready. When true, at the edge:
  - RB_Tag_Valid<=1; RB_Tag, RB_Rd and RB_Data take the head entry fields.
  - head valid<=0 and rptr+1.
- When the retire condition is false, RB_Tag_Valid<=0 and RB_Tag/RB_Rd/RB_Data hold their last values.
- At most one retire per cycle. Entries behind an incomplete head never retire, even if they are done.
- Push and retire on the same edge are both performed, and the occupancy count is unchanged. When full, the push is still rejected, because fullness is evaluated before the edge.
- Complete and retire in the same cycle are legal on different entries.
- Reset (any time, including mid-operation) sets wptr=rptr=0, clears all valid/done bits, and clears RB_Tag_Valid, RB_Tag, RB_Rd and RB_Data to 0. Any in-flight entries are discarded.

## Timing
- Reset values: RB_Tag_Valid=0, RB_Tag=0, RB_Rd=0, RB_Data=0, rq_empty=1, rq_full=0.
- Push at edge N: rq_empty falls after edge N. The entry can be completed by a CDB at edge N+1 at the earliest.
- Completion at edge N of the head entry with RF_Ready=1: RB_Tag_Valid is high during cycle N+1 (after edge N+1). CDB-to-retire latency is 1 cycle.
- Back-to-back completed entries with RF_Ready=1 keep RB_Tag_Valid high on consecutive cycles.
- RF_Ready low in cycle N means no retire at edge N. The head is held with no loss.
- The tag FIFO samples RB_Tag/RB_Tag_Valid on the edge after they are presented, so the tag returns to the FIFO 2 cycles after the head completes.

## Test plan
- Reset, then idle: RB_Tag_Valid=0, RB_Tag=0, rq_empty=1, rq_full=0. Asserting RF_Ready alone produces no retire.
- Push tags 3 and 7 (rd 1, 2); CDB 3/0xAAAA. One cycle later: RB_Tag_Valid=1, RB_Tag=3, RB_Rd=1, RB_Data=0xAAAA. Then CDB 7/0x5555 gives RB_Tag=7 next cycle.
- Push tags 0,1,2; CDB in order 2,1,0 on consecutive cycles. No retire until tag 0 completes. Then RB_Tag_Valid stays high for 3 cycles with RB_Tag=0,1,2.
- Push 32 entries: rq_full=1, and a 33rd Dispatch_en is ignored. Complete the head with RF_Ready=0 for 4 cycles: no retire. Raise RF_Ready: tag retires, and the next push plus wrap-around are accepted (wptr MSB toggles).
- Same-cycle push of tag 9 and retire of head: occupancy unchanged. A CDB for tag 9 in that same cycle is not recorded, and a CDB in the following cycle completes it.
- 5 entries outstanding, 2 done; assert reset mid-stream: all outputs 0 and rq_empty=1 immediately. A later CDB for an old tag produces no retire.

Source files
------------

// File: rtl/retire_queue_if.sv
// Bundle of the dispatch, CDB, register-file and tag-return signals around the
// retirement queue; the queue takes the slave modport.
interface retire_queue_if #(
  parameter int DSIZE = 5,
  parameter int RSIZE = 5,
  parameter int WSIZE = 32
);
  // Strobe semantics: Dispatch_en, CDB_Valid and RB_Tag_Valid each qualify
  // their payload for exactly the cycle they are high. Nothing is stalled back:
  // a dispatch while rq_full is dropped, and RF_Ready only gates retirement.
  logic             Dispatch_en;
  logic [DSIZE-1:0] Dispatch_Tag;
  logic [RSIZE-1:0] Dispatch_Rd;
  logic             CDB_Valid;
  logic [DSIZE-1:0] CDB_Tag;
  logic [WSIZE-1:0] CDB_Data;
  logic             RF_Ready;
  logic             RB_Tag_Valid;
  logic [DSIZE-1:0] RB_Tag;
  logic [RSIZE-1:0] RB_Rd;
  logic [WSIZE-1:0] RB_Data;
  logic             rq_full;
  logic             rq_empty;

  modport master (
    output Dispatch_en, Dispatch_Tag, Dispatch_Rd,
    output CDB_Valid, CDB_Tag, CDB_Data, RF_Ready,
    input  RB_Tag_Valid, RB_Tag, RB_Rd, RB_Data, rq_full, rq_empty
  );

  modport slave (
    input  Dispatch_en, Dispatch_Tag, Dispatch_Rd,
    input  CDB_Valid, CDB_Tag, CDB_Data, RF_Ready,
    output RB_Tag_Valid, RB_Tag, RB_Rd, RB_Data, rq_full, rq_empty
  );
endinterface

// File: rtl/retire_queue.sv
// In-order retirement queue: records dispatched tags, captures CDB results and
// retires completed heads in program order, returning each tag to the tag FIFO.
module retire_queue #(
  parameter int DSIZE = 5,
  parameter int ASIZE = 5,
  parameter int RSIZE = 5,
  parameter int WSIZE = 32
) (
  input logic          clock,
  input logic          reset,
  retire_queue_if.slave rq
);
  localparam int DEPTH = 1 << ASIZE;

  logic [ASIZE:0]   wptr_q, rptr_q;
  logic [DEPTH-1:0] valid_q, done_q;
  logic [DSIZE-1:0] tag_q  [DEPTH];
  logic [RSIZE-1:0] rd_q   [DEPTH];
  logic [WSIZE-1:0] data_q [DEPTH];

  logic             rb_valid_q;
  logic [DSIZE-1:0] rb_tag_q;
  logic [RSIZE-1:0] rb_rd_q;
  logic [WSIZE-1:0] rb_data_q;

  logic             empty, full, push, retire;
  logic [ASIZE-1:0] widx, ridx;
  logic [DEPTH-1:0] cdb_hit;

  assign widx   = wptr_q[ASIZE-1:0];
  assign ridx   = rptr_q[ASIZE-1:0];
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (widx == ridx);
  assign push   = rq.Dispatch_en && !full;
  assign retire = !empty && done_q[ridx] && rq.RF_Ready;

  // Only pending entries can match, so a slot being pushed this edge (still
  // invalid) and an already-done entry are both immune to the broadcast.
  always_comb begin
    cdb_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cdb_hit[i] = rq.CDB_Valid && valid_q[i] && !done_q[i] && (tag_q[i] == rq.CDB_Tag);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      rb_valid_q <= 1'b0;
      rb_tag_q   <= '0;
      rb_rd_q    <= '0;
      rb_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_hit[i]) done_q[i] <= 1'b1;
      end
      if (push) begin
        valid_q[widx] <= 1'b1;
        done_q[widx]  <= 1'b0;
        wptr_q        <= wptr_q + 1'b1;
      end
      rb_valid_q <= retire;
      if (retire) begin
        rb_tag_q      <= tag_q[ridx];
        rb_rd_q       <= rd_q[ridx];
        rb_data_q     <= data_q[ridx];
        valid_q[ridx] <= 1'b0;
        rptr_q        <= rptr_q + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: valid/done bits gate every use of it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit[i]) data_q[i] <= rq.CDB_Data;
    end
    if (push) begin
      tag_q[widx] <= rq.Dispatch_Tag;
      rd_q[widx]  <= rq.Dispatch_Rd;
    end
  end

  assign rq.RB_Tag_Valid = rb_valid_q;
  assign rq.RB_Tag       = rb_tag_q;
  assign rq.RB_Rd        = rb_rd_q;
  assign rq.RB_Data      = rb_data_q;
  assign rq.rq_full      = full;
  assign rq.rq_empty     = empty;
endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue: expected retirements go into a queue and a
// negedge monitor pops and compares every retire strobe.
module tb_retire_queue;
  logic clock;
  logic reset;

  retire_queue_if rq_if ();

  retire_queue dut (
    .clock (clock),
    .reset (reset),
    .rq    (rq_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int mon_checks = 0;
  int mon_passes = 0;

  // {tag, rd, data}
  logic [41:0] exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passes++;
  endtask

  task automatic push(input logic [4:0] tag, input logic [4:0] rd);
    rq_if.Dispatch_en  = 1'b1;
    rq_if.Dispatch_Tag = tag;
    rq_if.Dispatch_Rd  = rd;
    tick();
    rq_if.Dispatch_en  = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
    rq_if.CDB_Valid = 1'b1;
    rq_if.CDB_Tag   = tag;
    rq_if.CDB_Data  = data;
    tick();
    rq_if.CDB_Valid = 1'b0;
  endtask

  task automatic expect_retire(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({tag, rd, data});
  endtask

  // Monitor: every retire strobe must match the oldest expected retirement.
  always @(negedge clock) begin
    logic [41:0] exp;
    if (reset && rq_if.RB_Tag_Valid) begin
      mon_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_retire: got tag %0d rd %0d data %0h, expected no retire",
                 rq_if.RB_Tag, rq_if.RB_Rd, rq_if.RB_Data);
      end else begin
        exp = exp_q.pop_front();
        if ({rq_if.RB_Tag, rq_if.RB_Rd, rq_if.RB_Data} !== exp)
          $display("FAIL retire_payload: got tag %0d rd %0d data %0h, expected tag %0d rd %0d data %0h",
                   rq_if.RB_Tag, rq_if.RB_Rd, rq_if.RB_Data, exp[41:37], exp[36:32], exp[31:0]);
        else mon_passes++;
      end
    end
  end

  initial begin
    reset = 1'b0;
    rq_if.Dispatch_en  = 1'b0;
    rq_if.Dispatch_Tag = '0;
    rq_if.Dispatch_Rd  = '0;
    rq_if.CDB_Valid    = 1'b0;
    rq_if.CDB_Tag      = '0;
    rq_if.CDB_Data     = '0;
    rq_if.RF_Ready     = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Reset state, and RF_Ready alone does nothing
    check("reset_valid", rq_if.RB_Tag_Valid, 0);
    check("reset_tag",   rq_if.RB_Tag, 0);
    check("reset_rd",    rq_if.RB_Rd, 0);
    check("reset_data",  rq_if.RB_Data, 0);
    check("reset_empty", rq_if.rq_empty, 1);
    check("reset_full",  rq_if.rq_full, 0);
    rq_if.RF_Ready = 1'b1;
    repeat (3) tick();
    check("idle_no_retire", rq_if.RB_Tag_Valid, 0);

    // Basic push / complete / retire with 1-cycle latency
    push(3, 1);
    check("push_not_empty", rq_if.rq_empty, 0);
    push(7, 2);
    expect_retire(3, 1, 32'hAAAA);
    cdb(3, 32'hAAAA);
    check("latency_not_yet", rq_if.RB_Tag_Valid, 0);
    tick();
    check("retire3_valid", rq_if.RB_Tag_Valid, 1);
    check("retire3_tag",   rq_if.RB_Tag, 3);
    check("retire3_data",  rq_if.RB_Data, 32'hAAAA);
    expect_retire(7, 2, 32'h5555);
    cdb(7, 32'h5555);
    check("between_retires", rq_if.RB_Tag_Valid, 0);
    check("hold_tag", rq_if.RB_Tag, 3);
    tick();
    check("retire7_tag", rq_if.RB_Tag, 7);
    tick();
    check("drained_empty", rq_if.rq_empty, 1);
    check("drained_valid", rq_if.RB_Tag_Valid, 0);

    // Out-of-order completion, in-order retirement
    push(0, 10);
    push(1, 11);
    push(2, 12);
    cdb(2, 32'h222);
    cdb(1, 32'h111);
    tick();
    check("ooo_blocked", rq_if.RB_Tag_Valid, 0);
    expect_retire(0, 10, 32'h100);
    expect_retire(1, 11, 32'h111);
    expect_retire(2, 12, 32'h222);
    cdb(0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_valid", rq_if.RB_Tag_Valid, 1);
      check("b2b_tag", rq_if.RB_Tag, 64'(i));
    end
    tick();
    check("b2b_end", rq_if.RB_Tag_Valid, 0);
    check("b2b_empty", rq_if.rq_empty, 1);

    // Fill, overflow attempt, RF_Ready stall, wrap-around
    for (int i = 0; i < 32; i++) push(5'(i), 5'(i));
    check("full_set", rq_if.rq_full, 1);
    check("full_not_empty", rq_if.rq_empty, 0);
    push(5'd0, 5'd30);
    check("overflow_still_full", rq_if.rq_full, 1);
    rq_if.RF_Ready = 1'b0;
    cdb(0, 32'hF0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_no_retire", rq_if.RB_Tag_Valid, 0);
    end
    expect_retire(0, 0, 32'hF0);
    rq_if.RF_Ready = 1'b1;
    tick();
    check("stall_release_valid", rq_if.RB_Tag_Valid, 1);
    check("stall_release_tag", rq_if.RB_Tag, 0);
    check("after_retire_not_full", rq_if.rq_full, 0);
    push(5'd0, 5'd20);
    check("wrap_full_again", rq_if.rq_full, 1);
    for (int i = 1; i < 32; i++) begin
      expect_retire(5'(i), 5'(i), 32'h1000 + 32'(i));
      cdb(5'(i), 32'h1000 + 32'(i));
    end
    expect_retire(0, 20, 32'h2000);
    cdb(0, 32'h2000);
    tick();
    check("wrap_last_tag", rq_if.RB_Tag, 0);
    check("wrap_last_rd", rq_if.RB_Rd, 20);
    tick();
    check("wrap_empty", rq_if.rq_empty, 1);

    // Same-edge push and retire; same-edge CDB for the new tag is ignored
    push(4, 4);
    expect_retire(4, 4, 32'h44);
    cdb(4, 32'h44);
    rq_if.Dispatch_en  = 1'b1;
    rq_if.Dispatch_Tag = 5'd9;
    rq_if.Dispatch_Rd  = 5'd9;
    rq_if.CDB_Valid    = 1'b1;
    rq_if.CDB_Tag      = 5'd9;
    rq_if.CDB_Data     = 32'hDEAD;
    tick();
    rq_if.Dispatch_en  = 1'b0;
    rq_if.CDB_Valid    = 1'b0;
    check("pushret_valid", rq_if.RB_Tag_Valid, 1);
    check("pushret_tag", rq_if.RB_Tag, 4);
    check("pushret_occupied", rq_if.rq_empty, 0);
    tick();
    check("sameedge_cdb_ignored", rq_if.RB_Tag_Valid, 0);
    expect_retire(9, 9, 32'h9999);
    cdb(9, 32'h9999);
    tick();
    check("tag9_valid", rq_if.RB_Tag_Valid, 1);
    check("tag9_data", rq_if.RB_Data, 32'h9999);
    tick();

    // Mid-stream asynchronous reset
    for (int i = 10; i < 15; i++) push(5'(i), 5'(i));
    cdb(12, 32'hC);
    cdb(13, 32'hD);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", rq_if.RB_Tag_Valid, 0);
    check("midrst_tag",   rq_if.RB_Tag, 0);
    check("midrst_rd",    rq_if.RB_Rd, 0);
    check("midrst_data",  rq_if.RB_Data, 0);
    check("midrst_empty", rq_if.rq_empty, 1);
    check("midrst_full",  rq_if.rq_full, 0);
    tick();
    reset = 1'b1;
    cdb(10, 32'hA);
    tick();
    tick();
    check("stale_cdb_no_retire", rq_if.RB_Tag_Valid, 0);
    check("stale_empty", rq_if.rq_empty, 1);

    check("pending_retires", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes + mon_passes, checks + mon_checks);
    $finish;
  end
endmodule
